// File: rtl/imm_pkg.sv
// Shared types and instruction field positions for the immediate extender.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_DP   = 2'b00,
        IMM_MEM  = 2'b01,
        IMM_BR   = 2'b10,
        IMM_SX12 = 2'b11
    } imm_op_e;

    localparam int ROT_HI = 11;
    localparam int ROT_LO = 8;
    localparam int IMM8_W = 8;
    localparam int MEM_W  = 12;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension; shared by decode and the execute forwarding path.
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OFFS_W   = 24,
    parameter int BR_SHIFT = 2
) (
    input  logic [OFFS_W-1:0] offset,
    input  imm_op_e           op,
    output logic [DATA_W-1:0] value
);

    logic [DATA_W-1:0]           dp_base;
    logic [2*DATA_W-1:0]         dp_pair;
    logic [ROT_HI-ROT_LO+1:0]    dp_shift;
    logic [DATA_W-1:0]           dp_value;
    logic [DATA_W-1:0]           mem_value;
    logic [DATA_W-1:0]           br_sext;
    logic [DATA_W-1:0]           br_value;
    logic [DATA_W-1:0]           sx12_value;

    // Rotate by shifting a doubled copy so a zero rotate needs no special case.
    assign dp_base    = {{(DATA_W-IMM8_W){1'b0}}, offset[IMM8_W-1:0]};
    assign dp_shift   = {offset[ROT_HI:ROT_LO], 1'b0};
    assign dp_pair    = {dp_base, dp_base} >> dp_shift;
    assign dp_value   = dp_pair[DATA_W-1:0];

    assign mem_value  = {{(DATA_W-MEM_W){1'b0}}, offset[MEM_W-1:0]};
    assign br_sext    = {{(DATA_W-OFFS_W){offset[OFFS_W-1]}}, offset};
    assign br_value   = br_sext << BR_SHIFT;
    assign sx12_value = {{(DATA_W-MEM_W){offset[MEM_W-1]}}, offset[MEM_W-1:0]};

    always_comb begin
        value = '0;
        case (op)
            IMM_DP:   value = dp_value;
            IMM_MEM:  value = mem_value;
            IMM_BR:   value = br_value;
            IMM_SX12: value = sx12_value;
            default:  value = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready output and a one-entry skid buffer.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OFFS_W   = 24,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OFFS_W-1:0] offset,
    input  imm_op_e           op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] SignImm
);

    logic [DATA_W-1:0] ext_value;
    logic [DATA_W-1:0] or_data;
    logic [DATA_W-1:0] sk_data;
    logic              or_valid;
    logic              sk_valid;
    logic              accept;
    logic              or_free;

    imm_extend_core #(
        .DATA_W   (DATA_W),
        .OFFS_W   (OFFS_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .offset (offset),
        .op     (op),
        .value  (ext_value)
    );

    // in_ready comes straight from sk_valid, so out_ready never reaches it combinationally.
    assign accept  = in_valid & ~sk_valid;
    assign or_free = ~or_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            or_data  <= '0;
            sk_data  <= '0;
        end else if (flush) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
        end else if (or_free) begin
            if (sk_valid) begin
                or_data  <= sk_data;
                or_valid <= 1'b1;
                sk_valid <= 1'b0;
            end else if (accept) begin
                or_data  <= ext_value;
                or_valid <= 1'b1;
            end else begin
                or_valid <= 1'b0;
            end
        end else if (accept) begin
            sk_data  <= ext_value;
            sk_valid <= 1'b1;
        end
    end

    assign in_ready  = ~sk_valid;
    assign out_valid = or_valid;
    assign SignImm   = or_data;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench: stimulus pushes expected immediates, a monitor pops them on each output transfer.
module tb_imm_extend_pipe;
    import imm_pkg::*;

    typedef struct {
        imm_op_e     op;
        logic [23:0] off;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] offset;
    imm_op_e     op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SignImm;

    int          checks;
    int          errors;
    int          n_out;
    logic [31:0] exp_q[$];
    logic        was_stalled;
    logic [31:0] held_value;
    vec_t        vecs[12];

    imm_extend_pipe #(
        .DATA_W   (32),
        .OFFS_W   (24),
        .BR_SHIFT (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .offset    (offset),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SignImm   (SignImm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one input, wait (bounded) for acceptance, record the expected result.
    task automatic apply_stimulus(input imm_op_e o, input logic [23:0] off, input logic [31:0] exp);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        op       = o;
        offset   = off;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (!flush && !reset) exp_q.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 expected acceptance of %h", off);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: reset/flush discard everything in flight; otherwise compare each output transfer.
    always @(negedge clk) begin
        if (reset || flush) begin
            exp_q.delete();
            was_stalled = 1'b0;
        end else begin
            if (was_stalled) begin
                check_output("hold_valid", {31'b0, out_valid}, 32'd1);
                check_output("hold_data", SignImm, held_value);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got %h expected no output", SignImm);
                end else begin
                    check_output("output_order", SignImm, exp_q.pop_front());
                end
            end
            was_stalled = out_valid && !out_ready;
            held_value  = SignImm;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        checks      = 0;
        errors      = 0;
        n_out       = 0;
        was_stalled = 1'b0;
        held_value  = '0;
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        offset      = '0;
        op          = IMM_DP;

        vecs[0]  = '{IMM_BR,   24'hFFFFFE, 32'hFFFF_FFF8};
        vecs[1]  = '{IMM_BR,   24'h000010, 32'h0000_0040};
        vecs[2]  = '{IMM_DP,   24'h0004FF, 32'hFF00_0000};
        vecs[3]  = '{IMM_DP,   24'h0000FF, 32'h0000_00FF};
        vecs[4]  = '{IMM_DP,   24'h0001FF, 32'hC000_003F};
        vecs[5]  = '{IMM_SX12, 24'h000800, 32'hFFFF_F800};
        vecs[6]  = '{IMM_MEM,  24'h000800, 32'h0000_0800};
        vecs[7]  = '{IMM_MEM,  24'hABC123, 32'h0000_0123};
        vecs[8]  = '{IMM_SX12, 24'hFFF7FF, 32'h0000_07FF};
        vecs[9]  = '{IMM_DP,   24'h000F01, 32'h0000_0004};
        vecs[10] = '{IMM_BR,   24'h7FFFFF, 32'h01FF_FFFC};
        vecs[11] = '{IMM_BR,   24'h800000, 32'hFE00_0000};

        idle_cycles(2);
        reset = 1'b0;
        check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("reset_SignImm", SignImm, 32'd0);
        check_output("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Full throughput: every result appears one cycle after acceptance.
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].op, vecs[i].off, vecs[i].exp);
            check_output("latency_valid", {31'b0, out_valid}, 32'd1);
            check_output("latency_data", SignImm, vecs[i].exp);
            check_output("stream_in_ready", {31'b0, in_ready}, 32'd1);
        end
        idle_cycles(3);
        check_output("stream_count", n_out, 12);

        // Backpressure: A in OR, B in skid, C held by the source.
        base      = n_out;
        out_ready = 1'b0;
        apply_stimulus(IMM_BR, 24'h000001, 32'h0000_0004);
        apply_stimulus(IMM_MEM, 24'h000005, 32'h0000_0005);
        check_output("skid_full_in_ready", {31'b0, in_ready}, 32'd0);
        fork
            apply_stimulus(IMM_SX12, 24'h000FFF, 32'hFFFF_FFFF);
            begin
                idle_cycles(3);
                check_output("stall_valid", {31'b0, out_valid}, 32'd1);
                check_output("stall_data", SignImm, 32'h0000_0004);
                out_ready = 1'b1;
            end
        join
        idle_cycles(4);
        check_output("backpressure_count", n_out - base, 3);

        // Flush with OR and skid both full; the flush-cycle input must vanish.
        out_ready = 1'b0;
        apply_stimulus(IMM_BR, 24'h000002, 32'h0000_0008);
        apply_stimulus(IMM_MEM, 24'h000007, 32'h0000_0007);
        base     = n_out;
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = IMM_MEM;
        offset   = 24'h000099;
        idle_cycles(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        check_output("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        idle_cycles(4);
        check_output("flush_no_output", n_out - base, 0);

        // Reset in the middle of traffic, with an input presented in the reset cycle.
        apply_stimulus(IMM_DP, 24'h0003FF, 32'hFC00_0003);
        reset    = 1'b1;
        in_valid = 1'b1;
        op       = IMM_MEM;
        offset   = 24'h000123;
        idle_cycles(1);
        reset    = 1'b0;
        in_valid = 1'b0;
        check_output("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("midreset_SignImm", SignImm, 32'd0);
        check_output("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        apply_stimulus(IMM_DP, 24'h0002FF, 32'hF000_000F);
        check_output("post_reset_valid", {31'b0, out_valid}, 32'd1);
        check_output("post_reset_data", SignImm, 32'hF000_000F);
        idle_cycles(3);
        check_output("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
